afoote_w5s8_tt02_tape_unit: RTL

//  Tape store and head controller for the w5s8 UTM core. Holds the tape and

---
 rtl/afoote_w5s8_tt02_tape_pkg.sv | 18 +
 rtl/afoote_w5s8_tt02_tape_mem.sv | 35 +++
 rtl/afoote_w5s8_tt02_tape_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/afoote_w5s8_tt02_tape_pkg.sv
// Shared types and constants for the w5s8 tape unit.
// Holds the FSM state encoding, the blank symbol and the head directions.
package afoote_w5s8_tt02_tape_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_HALT    = 3'd3,
        ST_FAULT   = 3'd4,
        ST_TIMEOUT = 3'd5
    } tape_state_t;

    localparam logic [2:0] SYM_BLANK = 3'b000;
    localparam logic       DIR_LEFT  = 1'b0;
    localparam logic       DIR_RIGHT = 1'b1;

endpackage

// File: rtl/afoote_w5s8_tt02_tape_mem.sv
// Tape register file: DEPTH x 3-bit cells, one synchronous write port,
// two asynchronous read ports (a: head, b: debug); async clear on reset.
module afoote_w5s8_tt02_tape_mem
    import afoote_w5s8_tt02_tape_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [2:0]    wr_sym,
    input  logic [AW-1:0] ra_addr,
    output logic [2:0]    ra_sym,
    input  logic [AW-1:0] rb_addr,
    output logic [2:0]    rb_sym
);

    logic [2:0] cells [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cells[i] <= SYM_BLANK;
            end
        end else if (we) begin
            cells[wr_addr] <= wr_sym;
        end
    end

    assign ra_sym = cells[ra_addr];
    assign rb_sym = cells[rb_addr];

endmodule

// File: rtl/afoote_w5s8_tt02_tape_unit.sv
// Tape store and head controller for the w5s8 UTM core.
// Ports: clock/reset, preload (load_valid/load_sym), start, core step inputs
// (new_sym/direction/core_state), symbol feed (sym_out/sym_out_valid),
// head_pos, step_count, status (busy/halted/fault/timeout), debug rd_addr/rd_sym.
module afoote_w5s8_tt02_tape_unit
    import afoote_w5s8_tt02_tape_pkg::*;
#(
    parameter int          TAPE_LEN   = 16,
    parameter int          ADDR_W     = 4,
    parameter int          HEAD_INIT  = 8,
    parameter logic [2:0]  HALT_STATE = 3'd7,
    parameter logic [15:0] MAX_STEPS  = 16'hFFFF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [2:0]        load_sym,
    input  logic              start,
    input  logic [2:0]        new_sym,
    input  logic              direction,
    input  logic [2:0]        core_state,
    output logic [2:0]        sym_out,
    output logic              sym_out_valid,
    output logic [ADDR_W-1:0] head_pos,
    output logic [15:0]       step_count,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic              timeout,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        rd_sym
);

    localparam logic [ADDR_W-1:0] HEAD0 = ADDR_W'(HEAD_INIT);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(TAPE_LEN - 1);

    tape_state_t       state, state_nx;
    logic [ADDR_W-1:0] head, head_nx;
    logic [ADDR_W-1:0] ptr, ptr_nx;
    logic [15:0]       steps, steps_nx, steps_inc;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [2:0]        wr_sym;
    logic [2:0]        head_sym;
    logic              at_edge;

    afoote_w5s8_tt02_tape_mem #(
        .DEPTH (TAPE_LEN),
        .AW    (ADDR_W)
    ) u_mem (
        .clock   (clock),
        .reset   (reset),
        .we      (we),
        .wr_addr (wr_addr),
        .wr_sym  (wr_sym),
        .ra_addr (head),
        .ra_sym  (head_sym),
        .rb_addr (rd_addr),
        .rb_sym  (rd_sym)
    );

    // Saturating so the counter can never wrap past the limit.
    assign steps_inc = (steps == 16'hFFFF) ? steps : steps + 16'd1;

    // A move that would leave the tape.
    assign at_edge = ((direction == DIR_LEFT) && (head == '0)) ||
                     ((direction == DIR_RIGHT) && (head == LAST));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            head  <= HEAD0;
            ptr   <= '0;
            steps <= '0;
        end else begin
            state <= state_nx;
            head  <= head_nx;
            ptr   <= ptr_nx;
            steps <= steps_nx;
        end
    end

    always_comb begin
        state_nx = state;
        head_nx  = head;
        ptr_nx   = ptr;
        steps_nx = steps;
        we       = 1'b0;
        wr_addr  = ptr;
        wr_sym   = load_sym;
        case (state)
            ST_FETCH: begin
                state_nx = ST_EXEC;
            end
            ST_EXEC: begin
                we       = 1'b1;
                wr_addr  = head;
                wr_sym   = new_sym;
                steps_nx = steps_inc;
                if (core_state == HALT_STATE) begin
                    state_nx = ST_HALT;
                end else if (at_edge) begin
                    state_nx = ST_FAULT;
                end else begin
                    head_nx = (direction == DIR_RIGHT) ? head + 1'b1
                                                       : head - 1'b1;
                    state_nx = (steps_inc == MAX_STEPS) ? ST_TIMEOUT
                                                        : ST_FETCH;
                end
            end
            default: begin
                // Idle and terminal states accept preload and start.
                // A simultaneous load lands first; start then rewinds ptr.
                if (load_valid) begin
                    we     = 1'b1;
                    ptr_nx = ptr + 1'b1;
                end
                if (start) begin
                    head_nx  = HEAD0;
                    steps_nx = '0;
                    ptr_nx   = '0;
                    state_nx = ST_FETCH;
                end
            end
        endcase
    end

    assign sym_out_valid = (state == ST_FETCH);
    assign sym_out       = (state == ST_FETCH) ? head_sym : SYM_BLANK;
    assign head_pos      = head;
    assign step_count    = steps;
    assign busy          = (state == ST_FETCH) || (state == ST_EXEC);
    assign halted        = (state == ST_HALT);
    assign fault         = (state == ST_FAULT);
    assign timeout       = (state == ST_TIMEOUT);

endmodule
